// File: rtl/nibbler_pkg.sv
// nibbler_pkg: types and constants shared by the nibbler uP, its program memory and the loader
package nibbler_pkg;
  localparam int PROG_ADDR_W = 12;
  localparam int PROG_DATA_W = 8;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, RELEASE} loader_state_t;
endpackage

// File: rtl/program_loader_release_timer.sv
// release_timer: reloadable down-counter; expired_o is high once CYCLES cycles have passed since start_i
module release_timer #(
  parameter int CYCLES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  output logic expired_o
);
  localparam int CW = CYCLES > 0 ? $clog2(CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= start_i ? CW'(CYCLES) : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
  end
  assign expired_o = cnt_q == '0;
endmodule

// File: rtl/program_loader.sv
// program_loader: receives SYNC/LEN/data/CSUM frames, writes program memory and holds the uP
// in reset until a frame with a good checksum has been fully written.
module program_loader
  import nibbler_pkg::*;
#(
  parameter int ADDR_W        = PROG_ADDR_W,
  parameter int DATA_W        = PROG_DATA_W,
  parameter int RELEASE_CYC   = 2,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);
  loader_state_t     state_q;
  logic [3:0]        len_hi_q;
  logic [ADDR_W-1:0] cnt_q, addr_q, prog_addr_q;
  logic [DATA_W-1:0] sum_q, sum_d, prog_wdata_q;
  logic              prog_we_q, cpu_reset_q, busy_q, done_q, error_q;
  logic              take, tmr_start, tmr_expired;
  assign in_ready  = state_q != RELEASE;
  assign take      = in_valid && in_ready;
  assign sum_d     = sum_q + in_data;
  assign tmr_start = take && state_q == CSUM && sum_d == '0;
  release_timer #(.CYCLES(RELEASE_CYC)) u_timer (
    .clock     (clock),
    .reset     (reset),
    .start_i   (tmr_start),
    .expired_o (tmr_expired)
  );
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_hi_q     <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      sum_q        <= '0;
      prog_we_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_wdata_q <= '0;
      cpu_reset_q  <= HOLD_AT_RESET;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      prog_we_q <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: if (take && in_data == DATA_W'(SYNC_BYTE)) begin
          state_q     <= LEN_HI;
          busy_q      <= 1'b1;
          error_q     <= 1'b0;
          cpu_reset_q <= 1'b1;
          sum_q       <= '0;
        end
        LEN_HI: if (take) begin
          len_hi_q <= in_data[3:0];
          sum_q    <= sum_d;
          state_q  <= LEN_LO;
        end
        LEN_LO: if (take) begin
          cnt_q   <= ADDR_W'({len_hi_q, in_data});
          addr_q  <= '0;
          sum_q   <= sum_d;
          state_q <= DATA;
        end
        DATA: if (take) begin
          prog_we_q    <= 1'b1;
          prog_addr_q  <= addr_q;
          prog_wdata_q <= in_data;
          addr_q       <= addr_q + ADDR_W'(1);
          cnt_q        <= cnt_q - ADDR_W'(1);
          sum_q        <= sum_d;
          if (cnt_q == '0) state_q <= CSUM;
        end
        CSUM: if (take) begin
          state_q <= sum_d == '0 ? RELEASE : IDLE;
          error_q <= sum_d != '0;
          busy_q  <= sum_d == '0;
        end
        RELEASE: if (tmr_expired) begin
          cpu_reset_q <= 1'b0;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign prog_we    = prog_we_q;
  assign prog_addr  = prog_addr_q;
  assign prog_wdata = prog_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed frames; expected writes/done pulses queued by stimulus, checked by a monitor
module tb_program_loader;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, prog_we, cpu_reset, busy, done, error;
  logic [11:0] prog_addr;
  logic [7:0]  prog_wdata;
  logic [19:0] exp_q[$];
  logic [7:0]  fr[$];
  int          exp_done = 0;
  int          checks = 0;
  int          fails = 0;
  program_loader dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", n, got, want);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < fr.size(); i++) begin
      send(fr[i], gaps ? int'($urandom_range(0, 2)) : 0);
      if (i == 0) begin
        chk("sync_busy", 32'(busy), 32'd1);
        chk("sync_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("sync_error_clr", 32'(error), 32'd0);
      end
    end
  endtask
  task automatic check_good();
    tick();
    tick();
    chk("release_cpu_reset_held", 32'(cpu_reset), 32'd1);
    chk("release_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("good_done", 32'(done), 32'd1);
    chk("good_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("good_busy", 32'(busy), 32'd0);
    chk("good_error", 32'(error), 32'd0);
    repeat (3) tick();
  endtask
  task automatic check_bad();
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("bad_busy", 32'(busy), 32'd0);
    chk("bad_in_ready", 32'(in_ready), 32'd1);
    repeat (6) tick();
    chk("bad_cpu_reset_later", 32'(cpu_reset), 32'd1);
  endtask
  initial begin : monitor
    logic [19:0] e;
    forever begin
      @(negedge clock);
      if (prog_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wr_unexpected: got %03h:%02h, required no write", prog_addr, prog_wdata);
        end else begin
          e = exp_q.pop_front();
          if ({prog_addr, prog_wdata} !== e) begin
            fails++;
            $display("FAIL wr: got %03h:%02h, required %03h:%02h", prog_addr, prog_wdata, e[19:8], e[7:0]);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_done == 0 || cpu_reset !== 1'b0) begin
          fails++;
          $display("FAIL done_pulse: got done with cpu_reset=%0b pending=%0d, required pending>0 and cpu_reset=0", cpu_reset, exp_done);
        end else exp_done--;
      end
    end
  end
  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got no end of test, required finish within 1ms");
    $fatal(1, "timeout");
  end
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_prog_we", 32'(prog_we), 32'd0);
    chk("rst_prog_addr", 32'(prog_addr), 32'd0);
    chk("rst_prog_wdata", 32'(prog_wdata), 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_busy_done_error", {29'd0, busy, done, error}, 32'd0);
    reset = 1'b0;
    tick();
    // good frame
    exp_q.push_back({12'h000, 8'h10});
    exp_q.push_back({12'h001, 8'h20});
    exp_q.push_back({12'h002, 8'h30});
    exp_done++;
    fr = {8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h30, 8'h9E};
    send_frame(1'b0);
    check_good();
    // bad checksum: writes still happen, uP re-held
    exp_q.push_back({12'h000, 8'h10});
    exp_q.push_back({12'h001, 8'h20});
    exp_q.push_back({12'h002, 8'h30});
    fr = {8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h30, 8'h9F};
    send_frame(1'b0);
    check_bad();
    // garbage then the good frame with random gaps
    send(8'h00, 1);
    send(8'hFF, 2);
    send(8'h5A, 0);
    chk("garbage_error_kept", 32'(error), 32'd1);
    chk("garbage_busy", 32'(busy), 32'd0);
    exp_q.push_back({12'h000, 8'h10});
    exp_q.push_back({12'h001, 8'h20});
    exp_q.push_back({12'h002, 8'h30});
    exp_done++;
    fr = {8'hA5, 8'h00, 8'h02, 8'h10, 8'h20, 8'h30, 8'h9E};
    send_frame(1'b1);
    check_good();
    // full 4096-byte frame, data = address[7:0]
    fr = {8'hA5, 8'h0F, 8'hFF};
    for (int i = 0; i < 4096; i++) begin
      fr.push_back(i[7:0]);
      exp_q.push_back({i[11:0], i[7:0]});
    end
    fr.push_back(8'hF2);
    exp_done++;
    send_frame(1'b0);
    check_good();
    // reset mid-frame after the second data byte
    exp_q.push_back({12'h000, 8'h11});
    exp_q.push_back({12'h001, 8'h22});
    fr = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22};
    send_frame(1'b0);
    @(negedge clock);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_prog_we", 32'(prog_we), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    // frame containing 0xA5 as data, loaded from address 0
    exp_q.push_back({12'h000, 8'hA5});
    exp_done++;
    fr = {8'hA5, 8'h00, 8'h00, 8'hA5, 8'h5B};
    send_frame(1'b0);
    check_good();
    chk("idle_after_a5_data", 32'(busy), 32'd0);
    repeat (4) tick();
    chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
    chk("done_outstanding", 32'(exp_done), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
